sync_debounce_bank: RTL and testbench
=====================================

Name: sync_debounce_bank

Overview:
- Multi-channel successor to the single-input synchronizer/edge detector.
- Each of CHANNELS asynchronous inputs passes through an N-stage synchronizer, then a stability-count debouncer, then registered rise/fall tick generation.
- Debounced edges are also captured as pending events and presented one at a time on a valid/ready event port.
- Sits between board pins (buttons, IR receiver, switches) and consumer logic or a CPU-facing register block.

Parameters:
- CHANNELS, 4: number of independent input channels (1..16).
- SYNC_STAGES, 2: synchronizer flop depth per channel (>=2).
- DEBOUNCE_CYCLES, 4: consecutive synchronized cycles a new level must persist before it is accepted (>=1; 1 means no filtering).
- RESET_LEVEL, 0: value loaded into every sync stage and every debounced level on reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- async_in  in  CHANNELS  raw asynchronous inputs.
- level_out  out  CHANNELS  debounced level per channel.
- rise_tick  out  CHANNELS  1-cycle pulse on debounced 0->1.
- fall_tick  out  CHANNELS  1-cycle pulse on debounced 1->0.
- evt_valid  out  1  an event is presented.
- evt_ready  in  1  consumer accepts the event.
- evt_chan  out  clog2(CHANNELS) (min 1)  channel index of the presented event.
- evt_rise  out  1  1 = rising event, 0 = falling event.
- overrun  out  CHANNELS  sticky: an edge arrived while the same-type event on that channel was still pending.
- clr_overrun  in  CHANNELS  per-bit clear of overrun.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All sync flops and level_out go to RESET_LEVEL; debounce counters go to 0.
  - rise_tick, fall_tick, pending bits, evt_valid, evt_chan, evt_rise and overrun all go to 0.
  - No tick is generated by reset or its release. A mismatching input after release debounces normally.
  - Reset mid-debounce or mid-handshake discards all state, including a presented event.
- Synchronizer:
  - Shift chain per channel; s[i] is the last stage.
- Debounce, per channel, counter width clog2(DEBOUNCE_CYCLES+1):
  - If s == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= s, cnt <= 0, and the matching tick is asserted for exactly that one cycle.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no level change and no tick.
- Latency: counting the first clk edge that samples the new async value as edge 1, level_out and its tick update on edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults that is edge 6.
- Ticks: registered. A tick is asserted in the same cycle the new level_out first appears. rise_tick and fall_tick are never both set on one channel.
- Pending events:
  - Each channel has pend_r[i] and pend_f[i]; a tick sets the matching bit.
  - If a tick arrives while that bit is already set, overrun[i] <= 1. No event is queued for that tick; the existing event is kept.
  - If set and clear of the same pending bit coincide, set wins.
  - If set and clr_overrun coincide on an overrun bit, set wins.
- Event port:
  - When evt_valid=0 and any pending bit is set, the next cycle loads evt_valid=1 with the selection rule: lowest channel index first; within a channel, rise before fall.
  - evt_chan and evt_rise stay stable while evt_valid=1 && evt_ready=0.
  - On valid&&ready: the corresponding pending bit clears and evt_valid drops for one cycle. Throughput is therefore one event per 2 cycles.
  - evt_ready is ignored while evt_valid=0.
- Simultaneous ticks on several channels are all captured; none are lost.

Decomposition:
- Shared package/include holds:
  - clog2 function.
  - Localparams CNT_W = clog2(DEBOUNCE_CYCLES+1) and CHAN_W = max(1, clog2(CHANNELS)).
- Sub-module sync_debounce_ch: one channel's synchronizer, debounce counter, level register and tick registers. Instantiated CHANNELS times via generate.
- Top level holds the pending bits, the priority selector, the event register and the overrun logic.

Test Plan (defaults unless stated):
- Reset release with async_in=4'b0101 held -> level_out=0000 during reset; rise_tick[0] and rise_tick[2] pulse once on edge 6 after release; level_out=0101 afterwards.
- 3-cycle high glitch on async_in[1] -> level_out[1], rise_tick[1] and evt_valid stay 0. A 4-cycle-wide pulse instead -> rise_tick[1] pulses once, and fall_tick[1] pulses 4 cycles later.
- Channels 3 and 0 rise on the same cycle, evt_ready=1 -> events (chan0, rise) then (chan3, rise), two cycles apart; pending bits are empty afterwards.
- evt_ready=0; channel 2 rises, falls and rises again -> first event (2, rise) is held stable; pend_f[2] is set; overrun[2]=1 after the second rise. clr_overrun[2] pulse -> overrun[2]=0.
- rst asserted while evt_valid=1 and a counter is mid-count -> next cycle all outputs are 0 or RESET_LEVEL, and no stale event appears after release.
- SYNC_STAGES=3, DEBOUNCE_CYCLES=1, CHANNELS=1 -> a level change appears on edge 4; evt_chan width is 1 and always 0.

Source files
------------

// File: rtl/sync_debounce_bank_pkg.sv
// Shared helpers for the debounce bank.
// clog2       : ceiling log2 that is usable in parameter expressions.
// cnt_width   : width of one channel's debounce counter for a given DEBOUNCE_CYCLES.
// chan_width  : width of the event channel index (at least 1 bit).
// CNT_W/CHAN_W: the same widths evaluated for the default configuration.
package sync_debounce_bank_pkg;

  localparam int DEF_CHANNELS        = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int cnt_width(input int debounce_cycles);
    return clog2(debounce_cycles + 1);
  endfunction

  function automatic int chan_width(input int channels);
    return (channels <= 1) ? 1 : clog2(channels);
  endfunction

  localparam int CNT_W  = cnt_width(DEF_DEBOUNCE_CYCLES);
  localparam int CHAN_W = chan_width(DEF_CHANNELS);

endpackage

// File: rtl/sync_debounce_bank_if.sv
// Debounced-event handshake port.
// evt_valid : an event is presented (producer -> consumer)
// evt_ready : consumer accepts the presented event (consumer -> producer)
// evt_chan  : channel index of the presented event
// evt_rise  : 1 = rising event, 0 = falling event
interface sync_debounce_bank_if #(
  parameter int CHAN_W = 2
) ();
  logic              evt_valid;
  logic              evt_ready;
  logic [CHAN_W-1:0] evt_chan;
  logic              evt_rise;

  modport master (
    output evt_valid,
    output evt_chan,
    output evt_rise,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_chan,
    input  evt_rise,
    output evt_ready
  );
endinterface

// File: rtl/sync_debounce_bank_ch.sv
// One channel: synchronizer chain, stability-count debouncer, debounced level
// register and registered rise/fall ticks.
// clk, rst  : clock, synchronous active-high reset
// async_in  : raw asynchronous input
// level_out : debounced level
// rise_tick : 1-cycle pulse, first cycle of a debounced 0->1
// fall_tick : 1-cycle pulse, first cycle of a debounced 1->0
module sync_debounce_ch
  import sync_debounce_bank_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level_out,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int              CH_CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CH_CNT_W-1:0] CNT_LAST = CH_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CH_CNT_W-1:0]    cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    s       = sync_q[SYNC_STAGES-1];
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Level accepted; tick goes out in the same cycle the new level appears.
      level_d = s;
      cnt_d   = '0;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out = level_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;

endmodule

// File: rtl/sync_debounce_bank.sv
// Multi-channel synchronizer / debouncer with edge ticks and an event queue
// that presents pending debounced edges one at a time.
// clk, rst    : clock, synchronous active-high reset
// async_in    : raw asynchronous inputs, one per channel
// level_out   : debounced levels
// rise_tick   : 1-cycle pulses on debounced 0->1
// fall_tick   : 1-cycle pulses on debounced 1->0
// overrun     : sticky, an edge hit an already-pending same-type event
// clr_overrun : per-bit clear of overrun
// evt         : valid/ready event port (channel index + rise/fall)
module sync_debounce_bank
  import sync_debounce_bank_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_tick,
  output logic [CHANNELS-1:0] fall_tick,
  output logic [CHANNELS-1:0] overrun,
  input  logic [CHANNELS-1:0] clr_overrun,
  sync_debounce_bank_if.master evt
);

  localparam int TOP_CHAN_W = chan_width(CHANNELS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    sync_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .async_in (async_in[g]),
      .level_out(level_out[g]),
      .rise_tick(rise_tick[g]),
      .fall_tick(fall_tick[g])
    );
  end

  logic [CHANNELS-1:0]   pend_r_q, pend_r_d;
  logic [CHANNELS-1:0]   pend_f_q, pend_f_d;
  logic [CHANNELS-1:0]   ovr_q, ovr_d;
  logic [CHANNELS-1:0]   clr_r, clr_f;
  logic                  valid_q, valid_d;
  logic                  rise_q, rise_d;
  logic [TOP_CHAN_W-1:0] chan_q, chan_d;
  logic                  accept;

  always_comb begin
    accept = valid_q && evt.evt_ready;

    clr_r = '0;
    clr_f = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (accept && (chan_q == TOP_CHAN_W'(i))) begin
        clr_r[i] = rise_q;
        clr_f[i] = ~rise_q;
      end
    end

    // A new tick overrides a simultaneous clear of the same bit.
    pend_r_d = (pend_r_q & ~clr_r) | rise_tick;
    pend_f_d = (pend_f_q & ~clr_f) | fall_tick;

    // A pending bit that is being consumed this cycle does not count as
    // occupied; the new tick simply re-arms it.
    ovr_d = (ovr_q & ~clr_overrun)
          | (rise_tick & pend_r_q & ~clr_r)
          | (fall_tick & pend_f_q & ~clr_f);

    valid_d = valid_q;
    chan_d  = chan_q;
    rise_d  = rise_q;
    if (accept) begin
      valid_d = 1'b0;
    end else if (!valid_q && (|(pend_r_q | pend_f_q))) begin
      valid_d = 1'b1;
      // Scan high to low so the lowest pending channel wins; rise before fall.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (pend_r_q[i] || pend_f_q[i]) begin
          chan_d = TOP_CHAN_W'(i);
          rise_d = pend_r_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r_q <= '0;
      pend_f_q <= '0;
      ovr_q    <= '0;
      valid_q  <= 1'b0;
      chan_q   <= '0;
      rise_q   <= 1'b0;
    end else begin
      pend_r_q <= pend_r_d;
      pend_f_q <= pend_f_d;
      ovr_q    <= ovr_d;
      valid_q  <= valid_d;
      chan_q   <= chan_d;
      rise_q   <= rise_d;
    end
  end

  assign overrun       = ovr_q;
  assign evt.evt_valid = valid_q;
  assign evt.evt_chan  = chan_q;
  assign evt.evt_rise  = rise_q;

endmodule

// File: tb/tb_sync_debounce_bank.sv
module tb_sync_debounce_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] async_in, level_out, rise_tick, fall_tick, overrun, clr_overrun;

  logic [0:0] a1, lvl1, r1, f1, ov1, clr1;

  int n_checks = 0;
  int n_fail   = 0;

  sync_debounce_bank_if #(.CHAN_W(2)) evt_if ();
  sync_debounce_bank_if #(.CHAN_W(1)) evt1_if ();

  sync_debounce_bank #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .level_out(level_out),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .overrun(overrun),
    .clr_overrun(clr_overrun), .evt(evt_if)
  );

  sync_debounce_bank #(
    .CHANNELS(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .async_in(a1), .level_out(lvl1),
    .rise_tick(r1), .fall_tick(f1), .overrun(ov1),
    .clr_overrun(clr1), .evt(evt1_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    async_in = 4'b0101;
    clr_overrun = 4'b0000;
    evt_if.evt_ready = 1'b1;
    a1 = 1'b0;
    clr1 = 1'b0;
    evt1_if.evt_ready = 1'b1;

    // Reset with inputs already mismatching
    step(3);
    check("rst_level", level_out, 4'b0000);
    check("rst_rise", rise_tick, 4'b0000);
    check("rst_fall", fall_tick, 4'b0000);
    check("rst_valid", evt_if.evt_valid, 1'b0);
    check("rst_chan", evt_if.evt_chan, 2'd0);
    check("rst_erise", evt_if.evt_rise, 1'b0);
    check("rst_ovr", overrun, 4'b0000);
    check("rst_lvl1", lvl1, 1'b0);

    // Release: rise on edge 6, then events ch0 then ch2
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("rel_rise", rise_tick, (k == 6) ? 4'b0101 : 4'b0000);
      check("rel_fall", fall_tick, 4'b0000);
      check("rel_level", level_out, (k >= 6) ? 4'b0101 : 4'b0000);
      check("rel_valid", evt_if.evt_valid, (k == 8 || k == 10));
      if (k == 8) begin
        check("rel_chan0", evt_if.evt_chan, 2'd0);
        check("rel_erise0", evt_if.evt_rise, 1'b1);
      end
      if (k == 10) begin
        check("rel_chan2", evt_if.evt_chan, 2'd2);
        check("rel_erise2", evt_if.evt_rise, 1'b1);
      end
    end

    // 3-cycle glitch on ch1 is filtered
    async_in[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 3) async_in[1] = 1'b0;
      check("glitch_level1", level_out[1], 1'b0);
      check("glitch_rise1", rise_tick[1], 1'b0);
      check("glitch_valid", evt_if.evt_valid, 1'b0);
    end

    // 4-cycle pulse on ch1 passes: rise edge 6, fall edge 10
    async_in[1] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      if (k == 4) async_in[1] = 1'b0;
      check("pulse_rise1", rise_tick[1], (k == 6));
      check("pulse_fall1", fall_tick[1], (k == 10));
      check("pulse_level1", level_out[1], (k >= 6 && k < 10));
      check("pulse_valid", evt_if.evt_valid, (k == 8 || k == 12));
      if (k == 8 || k == 12) begin
        check("pulse_chan", evt_if.evt_chan, 2'd1);
        check("pulse_erise", evt_if.evt_rise, (k == 8));
      end
    end

    // Bring all channels low and drain the falls
    async_in = 4'b0000;
    step(14);
    check("low_level", level_out, 4'b0000);
    check("low_valid", evt_if.evt_valid, 1'b0);

    // Ch3 and ch0 rise together: ch0 event first, ch3 two cycles later
    async_in = 4'b1001;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("sim_rise", rise_tick, (k == 6) ? 4'b1001 : 4'b0000);
      check("sim_valid", evt_if.evt_valid, (k == 8 || k == 10));
      if (k == 8) begin
        check("sim_chan0", evt_if.evt_chan, 2'd0);
        check("sim_erise0", evt_if.evt_rise, 1'b1);
      end
      if (k == 10) begin
        check("sim_chan3", evt_if.evt_chan, 2'd3);
        check("sim_erise3", evt_if.evt_rise, 1'b1);
      end
    end
    step(2);
    check("sim_empty", evt_if.evt_valid, 1'b0);

    // Back-pressure on ch2: rise held, fall queued, second rise overruns
    evt_if.evt_ready = 1'b0;
    async_in[2] = 1'b1;
    step(8);
    check("bp_valid", evt_if.evt_valid, 1'b1);
    check("bp_chan", evt_if.evt_chan, 2'd2);
    check("bp_erise", evt_if.evt_rise, 1'b1);
    step(2);
    async_in[2] = 1'b0;
    step(6);
    check("bp_fall2", fall_tick[2], 1'b1);
    check("bp_ovr_fall", overrun, 4'b0000);
    step(1);
    async_in[2] = 1'b1;
    step(6);
    check("bp_rise2", rise_tick[2], 1'b1);
    check("bp_ovr_pre", overrun, 4'b0000);
    step(1);
    check("bp_ovr_set", overrun, 4'b0100);
    check("bp_hold_valid", evt_if.evt_valid, 1'b1);
    check("bp_hold_chan", evt_if.evt_chan, 2'd2);
    check("bp_hold_erise", evt_if.evt_rise, 1'b1);
    clr_overrun = 4'b0100;
    step(1);
    clr_overrun = 4'b0000;
    check("bp_ovr_clr", overrun, 4'b0000);
    evt_if.evt_ready = 1'b1;
    step(1);
    check("bp_drop", evt_if.evt_valid, 1'b0);
    step(1);
    check("bp_fall_valid", evt_if.evt_valid, 1'b1);
    check("bp_fall_chan", evt_if.evt_chan, 2'd2);
    check("bp_fall_erise", evt_if.evt_rise, 1'b0);
    step(1);
    check("bp_drop2", evt_if.evt_valid, 1'b0);
    step(2);
    check("bp_empty", evt_if.evt_valid, 1'b0);

    // Reset mid-handshake with ch3 mid-count
    evt_if.evt_ready = 1'b0;
    async_in = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (k == 5) async_in = 4'b0111;
    end
    check("mid_valid", evt_if.evt_valid, 1'b1);
    check("mid_chan", evt_if.evt_chan, 2'd1);
    rst = 1'b1;
    step(1);
    check("mr_level", level_out, 4'b0000);
    check("mr_rise", rise_tick, 4'b0000);
    check("mr_fall", fall_tick, 4'b0000);
    check("mr_valid", evt_if.evt_valid, 1'b0);
    check("mr_chan", evt_if.evt_chan, 2'd0);
    check("mr_erise", evt_if.evt_rise, 1'b0);
    check("mr_ovr", overrun, 4'b0000);
    step(1);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("post_rise", rise_tick, (k == 6) ? 4'b0111 : 4'b0000);
      check("post_valid", evt_if.evt_valid, (k >= 8));
    end
    check("post_chan", evt_if.evt_chan, 2'd0);
    check("post_erise", evt_if.evt_rise, 1'b1);
    evt_if.evt_ready = 1'b1;
    step(6);
    check("post_empty", evt_if.evt_valid, 1'b0);

    // 1-channel, 3-stage, no-filter instance: level on edge 4
    a1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check("c1_level", lvl1, (k >= 4));
      check("c1_rise", r1, (k == 4));
      check("c1_chan", evt1_if.evt_chan, 1'b0);
      check("c1_valid", evt1_if.evt_valid, (k == 6));
    end
    check("c1_erise", evt1_if.evt_rise, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
